// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between instruction
// fetch (I), load/store (D) and a DMA engine (M). Priority D > I > M, with an
// aging counter that forces M through after STARVE_MAX consecutive losses.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port (read-only)
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // DMA port
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [3:0]        m_be,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LastWait  = 4'(MEM_LAT - 1);
  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD, OwnM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              acc_we_q, acc_we_d;
  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d, m_gnt_q, m_gnt_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              busy_q, busy_d;
  logic              last_wait, arb_point;
  logic [DATA_W-1:0] rsp_data;

  // Arbitration: pick the winner at IDLE or in the last WAIT cycle.
  always_comb begin
    last_wait = (state_q == StWait) && (wait_cnt_q == LastWait);
    arb_point = (state_q == StIdle) || last_wait;
    winner    = OwnNone;
    if (arb_point) begin
      if (m_req && (starve_cnt_q == StarveMax)) winner = OwnM;
      else if (d_req)                           winner = OwnD;
      else if (i_req)                           winner = OwnI;
      else if (m_req)                           winner = OwnM;
    end
  end

  // Next state, aging counter and registered grant/memory outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wait_cnt_d   = '0;
    starve_cnt_d = starve_cnt_q;
    acc_we_d     = acc_we_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    m_gnt_d      = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;

    case (state_q)
      StIssue: state_d = StWait;
      StWait:  if (!last_wait) wait_cnt_d = wait_cnt_q + 4'd1;
      default: ;
    endcase

    if (arb_point) begin
      state_d = StIdle;
      owner_d = OwnNone;
      // M only ages while it is actually asking; a win or an idle M resets it.
      if (!m_req || (winner == OwnM))      starve_cnt_d = '0;
      else if (starve_cnt_q != StarveMax)  starve_cnt_d = starve_cnt_q + 8'd1;

      case (winner)
        OwnI: begin
          i_gnt_d     = 1'b1;
          acc_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end
        OwnD: begin
          d_gnt_d     = 1'b1;
          acc_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end
        OwnM: begin
          m_gnt_d     = 1'b1;
          acc_we_d    = m_we;
          mem_addr_d  = m_addr;
          mem_wdata_d = m_wdata;
          mem_be_d    = m_be;
        end
        default: ;
      endcase

      if (winner != OwnNone) begin
        state_d  = StIssue;
        owner_d  = winner;
        mem_en_d = 1'b1;
        mem_we_d = acc_we_d;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers; synchronous reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnNone;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      acc_we_q     <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      m_gnt_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      acc_we_q     <= acc_we_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
      m_gnt_q      <= m_gnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      busy_q       <= busy_d;
    end
  end

  // Response steering: only the owner sees rvalid; writes return zero data.
  always_comb begin
    rsp_data = acc_we_q ? '0 : mem_rdata;
    i_rvalid = last_wait && (owner_q == OwnI);
    d_rvalid = last_wait && (owner_q == OwnD);
    m_rvalid = last_wait && (owner_q == OwnM);
    i_rdata  = i_rvalid ? rsp_data : '0;
    d_rdata  = d_rvalid ? rsp_data : '0;
    m_rdata  = m_rvalid ? rsp_data : '0;
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign m_gnt     = m_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between three requesters: instruction fetch (I), MEM-stage load/store (D), and the camera/frame DMA engine (M).
- Serialises accesses with fixed-latency memory timing and returns one response per grant.
- Fetch and MEM stages treat "req high and no rvalid" as a stall.
- DMA is protected from starvation by an aging counter.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 8, number of consecutive lost arbitrations after which DMA is forced to win; legal range 1..255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request (read-only)
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted
- i_rvalid  out  1  fetch response valid
- i_rdata  out  DATA_W  fetch read data
- d_req, d_we  in  1 each  data request; write enable
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_be  in  4  data byte enables
- d_gnt, d_rvalid  out  1 each  data grant; data response valid
- d_rdata  out  DATA_W  data read data
- m_req, m_we, m_addr, m_wdata, m_be, m_gnt, m_rvalid, m_rdata  (same directions and widths as the d_* ports)  DMA port
- mem_en, mem_we  out  1 each  memory access strobe; memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered except *_rdata and *_rvalid.
- Arbitration point: any cycle in IDLE, or the last WAIT cycle (wait_cnt == MEM_LAT-1).
- Priority at an arbitration point: D > I > M, except M wins outright when starve_cnt == STARVE_MAX and m_req=1.
- Arbitration with no request pending: IDLE -> IDLE; last WAIT -> IDLE.
- Winner in cycle T:
  - latch owner, addr, wdata, we and be (I port: we=0, be=4'hF);
  - state=ISSUE in T+1, with mem_en=1 and the latched mem_* values driven, and owner's *_gnt=1 for that single cycle.
- Requester handshake: the requester holds req and its payload stable through the cycle its gnt is high. A req still high in the cycle after gnt is a new request.
- WAIT timing: after ISSUE, WAIT lasts exactly MEM_LAT cycles; wait_cnt counts 0..MEM_LAT-1.
- Response: in the last WAIT cycle the owner's *_rvalid=1 and *_rdata=mem_rdata. Writes also get rvalid (as an ack) with rdata=0.
- Non-owner rdata/rvalid are 0 at all times.
- Throughput: one access per MEM_LAT+1 cycles; back-to-back accesses have no IDLE bubble.
- Starvation counter:
  - starve_cnt (8-bit) increments by 1 at each arbitration point where m_req=1 and M loses; saturates at STARVE_MAX;
  - clears to 0 when M wins or at any arbitration point with m_req=0.
- Simultaneous events: a requester receiving its rvalid may present a new req in the same cycle and is arbitrated normally in that cycle.
- mem_en is never high for two consecutive cycles.
- mem_we is 0 whenever mem_en=0; mem_addr, mem_wdata and mem_be hold their last value.
- Reset (synchronous, highest priority, including mid-access):
  - state=IDLE, wait_cnt=0, starve_cnt=0, owner cleared;
  - all gnt/rvalid/mem_en/mem_we=0, all mem_* buses=0, busy=0;
  - an in-flight access is abandoned and produces no rvalid.
- An access with a req deasserted before gnt is dropped silently (legal, no error).

Test Plan:
1. MEM_LAT=2, i_req=1, addr=0x100, memory returns 0xDEADBEEF → mem_en at T+1 with mem_addr=0x100, i_gnt at T+1, i_rvalid=1 and i_rdata=0xDEADBEEF at T+3, busy=1 for T+1..T+3.
2. d_req and i_req both high in the same cycle → D granted first; I granted in D's rvalid cycle+1 with no IDLE gap; mem_en pulses spaced exactly 3 cycles apart.
3. D write, addr=0x2000, wdata=0x12345678, be=4'b0011 → mem_we=1, mem_be=4'b0011 during ISSUE; d_rvalid=1 with d_rdata=0 two cycles later.
4. STARVE_MAX=4, d_req and i_req alternating continuously, m_req held high → M loses 4 arbitrations, wins the 5th; starve_cnt returns to 0 after the M grant.
5. rst asserted in the first WAIT cycle of an I read → next cycle busy=0, all outputs 0, no i_rvalid ever appears; a fresh i_req after reset completes normally.
6. MEM_LAT=1, continuous d_req → mem_en every 2nd cycle, d_rvalid in every cycle between them, and i_req held high is starved indefinitely. This is the accepted behaviour; only M ages.
